// File: rtl/ram_saida_mux_pkg.sv
// Shared types and defaults for the segment RAM with display scan multiplexer.
package ram_saida_mux_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int          LINHAS_DEF  = 11;
    localparam int          COLUNAS_DEF = 11;
    localparam logic [31:0] BLANK_DEF   = 32'h0000_007E;

    // Address width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_saida_mux_scan_mux.sv
// Time-multiplexed display scan: slot counter, display index and registered anode/segment drive.
module scan_mux
    import ram_saida_mux_pkg::*;
#(
    parameter int                DATA_W   = 7,
    parameter int                N_DISP   = 8,
    parameter int                SCAN_DIV = 50000,
    parameter logic [DATA_W-1:0] BLANK    = BLANK_DEF[DATA_W-1:0]
) (
    input  logic                           clock,
    input  logic                           resetCPU,
    input  logic                           ready,
    input  logic [N_DISP-1:0][DATA_W-1:0]  row0,
    output logic [DATA_W-1:0]              seg,
    output logic [N_DISP-1:0]              anodo
);

    localparam int CNT_W = addr_w(SCAN_DIV);
    localparam int IDX_W = addr_w(N_DISP);

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [N_DISP-1:0] sel;

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            cnt   <= '0;
            idx   <= '0;
            seg   <= BLANK;
            anodo <= '1;
        end else begin
            if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(N_DISP - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Displays stay dark while the RAM is being cleared.
            seg   <= ready ? row0[idx] : BLANK;
            anodo <= ready ? ~sel : '1;
        end
    end

endmodule

// File: rtl/ram_saida_mux.sv
// Segment-pattern RAM with blanking sweep, registered read port and multiplexed display scan.
module ram_saida_mux
    import ram_saida_mux_pkg::*;
#(
    parameter int                LINHAS   = LINHAS_DEF,
    parameter int                COLUNAS  = COLUNAS_DEF,
    parameter int                DATA_W   = 7,
    parameter int                N_DISP   = 8,
    parameter int                SCAN_DIV = 50000,
    parameter logic [DATA_W-1:0] BLANK    = BLANK_DEF[DATA_W-1:0]
) (
    input  logic                         clock,
    input  logic                         resetCPU,
    input  logic [DATA_W-1:0]            data,
    input  logic [addr_w(LINHAS)-1:0]    end_linha,
    input  logic [addr_w(COLUNAS)-1:0]   end_coluna,
    input  logic                         write,
    input  logic                         read,
    input  logic                         limpar,
    output logic                         ready,
    output logic [31:0]                  saida,
    output logic                         saida_valid,
    output logic                         erro,
    output logic [N_DISP*DATA_W-1:0]     displays,
    output logic [DATA_W-1:0]            seg,
    output logic [N_DISP-1:0]            anodo
);

    localparam int LIN_W = addr_w(LINHAS);
    localparam int COL_W = addr_w(COLUNAS);

    state_t                        state, next_state;
    logic [LIN_W-1:0]              sw_lin;
    logic [COL_W-1:0]              sw_col;
    logic [DATA_W-1:0]             mem [LINHAS][COLUNAS];
    logic                          addr_ok;
    logic                          sweep_last;
    logic [N_DISP-1:0][DATA_W-1:0] row0;

    assign addr_ok = ({1'b0, end_linha}  < (LIN_W + 1)'(LINHAS)) &&
                     ({1'b0, end_coluna} < (COL_W + 1)'(COLUNAS));
    assign sweep_last = (sw_lin == LIN_W'(LINHAS - 1)) && (sw_col == COL_W'(COLUNAS - 1));

    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) state <= ST_CLEAR;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (!limpar && sweep_last) next_state = ST_IDLE;
            ST_IDLE:  if (limpar)                next_state = ST_CLEAR;
            default:                             next_state = ST_CLEAR;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
    end

    // Sweep pointer rests at (0,0) outside CLEAR so every clear starts from the origin.
    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            sw_lin <= '0;
            sw_col <= '0;
        end else if (state != ST_CLEAR || limpar || sweep_last) begin
            sw_lin <= '0;
            sw_col <= '0;
        end else if (sw_col == COL_W'(COLUNAS - 1)) begin
            sw_col <= '0;
            sw_lin <= sw_lin + LIN_W'(1);
        end else begin
            sw_col <= sw_col + COL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (state == ST_CLEAR)      mem[sw_lin][sw_col]        <= BLANK;
        else if (write && addr_ok)  mem[end_linha][end_coluna] <= data;
    end

    // Read samples the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            saida       <= '0;
            saida_valid <= 1'b0;
            erro        <= 1'b0;
        end else begin
            saida_valid <= ready && read;
            erro        <= ready && (read || write) && !addr_ok;
            if (ready && read)
                saida <= addr_ok ? 32'(mem[end_linha][end_coluna]) : '0;
        end
    end

    for (genvar i = 0; i < N_DISP; i++) begin : g_row0
        assign row0[i] = mem[0][i];
    end
    assign displays = row0;

    scan_mux #(
        .DATA_W   (DATA_W),
        .N_DISP   (N_DISP),
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_scan (
        .clock    (clock),
        .resetCPU (resetCPU),
        .ready    (ready),
        .row0     (row0),
        .seg      (seg),
        .anodo    (anodo)
    );

endmodule

// File: tb/tb_ram_saida_mux.sv
// Scoreboard bench for ram_saida_mux with a fast scan divider.
module tb_ram_saida_mux;

    localparam int          NL    = 11;
    localparam int          NC    = 11;
    localparam logic [6:0]  BLK   = 7'h7E;
    localparam int          SWEEP = NL * NC;

    logic        clock;
    logic        resetCPU;
    logic [6:0]  data;
    logic [3:0]  end_linha;
    logic [3:0]  end_coluna;
    logic        write;
    logic        read;
    logic        limpar;
    logic        ready;
    logic [31:0] saida;
    logic        saida_valid;
    logic        erro;
    logic [55:0] displays;
    logic [6:0]  seg;
    logic [7:0]  anodo;

    ram_saida_mux #(
        .LINHAS   (NL),
        .COLUNAS  (NC),
        .DATA_W   (7),
        .N_DISP   (8),
        .SCAN_DIV (4),
        .BLANK    (BLK)
    ) dut (
        .clock       (clock),
        .resetCPU    (resetCPU),
        .data        (data),
        .end_linha   (end_linha),
        .end_coluna  (end_coluna),
        .write       (write),
        .read        (read),
        .limpar      (limpar),
        .ready       (ready),
        .saida       (saida),
        .saida_valid (saida_valid),
        .erro        (erro),
        .displays    (displays),
        .seg         (seg),
        .anodo       (anodo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  model [NL][NC];
    logic [31:0] sb_q [$];
    int          clear_left = SWEEP;
    int          scnt = 0;
    int          sidx = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; expectations come from the bench model, checked just after the edge.
    task automatic cycle(input logic w, input logic r, input logic lim,
                         input int lin, input int col, input logic [6:0] d);
        logic       rdy_m;
        logic       inr;
        logic       exp_erro;
        logic       exp_vld;
        logic [6:0] exp_seg;
        logic [7:0] exp_an;
        write = w; read = r; limpar = lim; data = d;
        end_linha = 4'(lin); end_coluna = 4'(col);
        rdy_m = (clear_left == 0);
        chk_eq("ready", 64'(ready), 64'(rdy_m));
        inr = (lin < NL) && (col < NC);
        exp_erro = rdy_m && (w || r) && !inr;
        if (rdy_m && r) sb_q.push_back(inr ? 32'(model[lin][col]) : 32'd0);
        exp_an  = rdy_m ? ~(8'd1 << sidx) : 8'hFF;
        exp_seg = rdy_m ? model[0][sidx] : BLK;
        if (rdy_m && w && inr) model[lin][col] = d;
        if (lim) begin
            clear_left = SWEEP;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0)
                for (int i = 0; i < NL; i++)
                    for (int j = 0; j < NC; j++) model[i][j] = BLK;
        end
        if (scnt == 3) begin
            scnt = 0;
            sidx = (sidx + 1) % 8;
        end else begin
            scnt++;
        end
        @(posedge clock); #1;
        exp_vld = (sb_q.size() > 0);
        chk_eq("saida_valid", 64'(saida_valid), 64'(exp_vld));
        if (exp_vld) chk_eq("saida", 64'(saida), 64'(sb_q.pop_front()));
        chk_eq("erro", 64'(erro), 64'(exp_erro));
        chk_eq("anodo", 64'(anodo), 64'(exp_an));
        chk_eq("seg", 64'(seg), 64'(exp_seg));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 7'h00);
    endtask

    task automatic read_all();
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NC; j++) cycle(1'b0, 1'b1, 1'b0, i, j, 7'h00);
    endtask

    task automatic check_displays();
        logic [55:0] exp_d;
        for (int i = 0; i < 8; i++) exp_d[i*7 +: 7] = model[0][i];
        chk_eq("displays", 64'(displays), 64'(exp_d));
    endtask

    task automatic do_reset();
        write = 1'b0; read = 1'b0; limpar = 1'b0;
        resetCPU = 1'b1;
        #2;
        chk_eq("rst_ready", 64'(ready), 64'd0);
        chk_eq("rst_saida", 64'(saida), 64'd0);
        chk_eq("rst_valid", 64'(saida_valid), 64'd0);
        chk_eq("rst_erro", 64'(erro), 64'd0);
        chk_eq("rst_seg", 64'(seg), 64'(BLK));
        chk_eq("rst_anodo", 64'(anodo), 64'hFF);
        @(posedge clock); #1;
        resetCPU = 1'b0;
        clear_left = SWEEP;
        scnt = 0;
        sidx = 0;
        sb_q.delete();
    endtask

    initial begin
        resetCPU = 1'b0; data = '0; end_linha = '0; end_coluna = '0;
        write = 1'b0; read = 1'b0; limpar = 1'b0;
        #1;
        do_reset();
        repeat (SWEEP) idle();

        // Corners after the first sweep, then basic write/read and display mapping
        cycle(1'b0, 1'b1, 1'b0, 10, 10, 7'h00);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 7'h00);
        cycle(1'b1, 1'b0, 1'b0, 0, 2, 7'h30);
        cycle(1'b0, 1'b1, 1'b0, 0, 2, 7'h00);
        chk_eq("disp2", 64'(displays[2*7 +: 7]), 64'h30);

        // Same-address read and write, then out-of-range accesses
        cycle(1'b1, 1'b1, 1'b0, 3, 4, 7'h55);
        cycle(1'b0, 1'b1, 1'b0, 3, 4, 7'h00);
        cycle(1'b1, 1'b0, 1'b0, 12, 0, 7'h01);
        cycle(1'b0, 1'b1, 1'b0, 0, 11, 7'h00);
        cycle(1'b1, 1'b1, 1'b0, 15, 15, 7'h01);
        read_all();

        // Distinct row-0 patterns so the scan walks visible data
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 0, i, 7'(i * 9 + 1));
        check_displays();
        repeat (40) idle();
        cycle(1'b1, 1'b0, 1'b0, 0, sidx, 7'h6B);
        repeat (6) idle();

        // Combined access with clear request; accesses during the sweep are ignored
        cycle(1'b1, 1'b1, 1'b1, 5, 5, 7'h2A);
        cycle(1'b1, 1'b1, 1'b0, 5, 5, 7'h11);
        cycle(1'b1, 1'b1, 1'b0, 13, 0, 7'h11);
        repeat (SWEEP) idle();
        check_displays();
        read_all();

        // Clear request while already clearing restarts the sweep
        cycle(1'b1, 1'b0, 1'b0, 7, 7, 7'h3C);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 7'h00);
        repeat (30) idle();
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 7'h00);
        repeat (SWEEP + 2) idle();
        cycle(1'b0, 1'b1, 1'b0, 7, 7, 7'h00);

        // Reset pulse in the middle of a sweep
        cycle(1'b1, 1'b0, 1'b0, 1, 1, 7'h05);
        cycle(1'b1, 1'b0, 1'b0, 0, 1, 7'h44);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 7'h00);
        repeat (40) idle();
        do_reset();
        repeat (SWEEP + 3) idle();
        read_all();
        check_displays();

        chk_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
